// File: rtl/bp_fe_ras_linked_pkg.sv
// bp_fe_ras_linked_pkg: shared types for the pointer-linked return address stack.
// Configuration macro: BP_FE_RAS_UNDERFLOW_GUARD_EN selects whether the
// per-entry link_v bit exists in the entry type.
package bp_fe_ras_linked_pkg;

  // Controller states: sweep the valid bits after reset, then run forever.
  typedef enum logic {
    e_clear = 1'b0,
    e_run   = 1'b1
  } bp_fe_ras_state_e;

endpackage

// Entry layout, parametrised by target and pointer width. The link_v field
// tracks whether the link points at a live entry; without the underflow
// guard it is not part of the entry at all.
`ifdef BP_FE_RAS_UNDERFLOW_GUARD_EN
`define BP_FE_DECLARE_RAS_ENTRY_S(vaddr_width_mp, idx_width_mp) \
  typedef struct packed {                                   \
    logic [vaddr_width_mp-1:0] tgt;                         \
    logic [idx_width_mp-1:0]   link;                        \
    logic                      link_v;                      \
    logic                      valid;                       \
  } bp_fe_ras_entry_s
`else
`define BP_FE_DECLARE_RAS_ENTRY_S(vaddr_width_mp, idx_width_mp) \
  typedef struct packed {                                   \
    logic [vaddr_width_mp-1:0] tgt;                         \
    logic [idx_width_mp-1:0]   link;                        \
    logic                      valid;                       \
  } bp_fe_ras_entry_s
`endif

// File: rtl/bp_fe_ras_linked_if.sv
// bp_fe_ras_linked_if: push/pop/restore request bundle and stack read-out.
// master = front-end logic driving calls/returns, slave = the RAS itself.
interface bp_fe_ras_linked_if #(
  parameter int vaddr_width_p = 39,
  parameter int ras_els_p     = 8
);
  localparam int ras_idx_width_lp = $clog2(ras_els_p);

  logic                        init_done_o;
  logic                        call_i;
  logic [vaddr_width_p-1:0]    addr_i;
  logic                        return_i;
  logic                        restore_i;
  logic [ras_idx_width_lp-1:0] w_next_i;
  logic [ras_idx_width_lp-1:0] w_tos_i;
  logic                        v_o;
  logic [vaddr_width_p-1:0]    tgt_o;
  logic [ras_idx_width_lp-1:0] next_o;
  logic [ras_idx_width_lp-1:0] tos_o;

  modport master (
    output call_i, addr_i, return_i, restore_i, w_next_i, w_tos_i,
    input  init_done_o, v_o, tgt_o, next_o, tos_o
  );

  modport slave (
    input  call_i, addr_i, return_i, restore_i, w_next_i, w_tos_i,
    output init_done_o, v_o, tgt_o, next_o, tos_o
  );
endinterface

// File: rtl/bp_fe_ras_linked_mem_1r1w.sv
// bp_fe_ras_linked_mem_1r1w: target/link storage array for the RAS.
// Synchronous write, asynchronous read.
module bp_fe_ras_linked_mem_1r1w #(
  parameter int width_p = 8,
  parameter int els_p   = 8,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  // Write port: one entry per cycle when a push is accepted.
  // NOTE: the array has no reset; validity lives in separate reset flops,
  // so stale array contents are never exposed as a usable target.
  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_fe_ras_linked.sv
// bp_fe_ras_linked: pointer-linked return address stack with checkpointable
// next/tos pointers. Pops are non-destructive; an entry lives until a push
// wraps onto it, so restoring an old {next, tos} recovers the right target.
// Configuration macro: BP_FE_RAS_UNDERFLOW_GUARD_EN (adds tos_v/link_v so a
// pop past the bottom deasserts v_o even on a stale-valid entry).
module bp_fe_ras_linked
  import bp_fe_ras_linked_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int ras_els_p     = 8,
  localparam int ras_idx_width_lp = $clog2(ras_els_p)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  bp_fe_ras_linked_if.slave ras
);

  `BP_FE_DECLARE_RAS_ENTRY_S(vaddr_width_p, ras_idx_width_lp);

  localparam int mem_width_lp = vaddr_width_p + ras_idx_width_lp;
  localparam logic [ras_idx_width_lp-1:0] last_idx_lp = ras_idx_width_lp'(ras_els_p - 1);
  localparam logic [ras_idx_width_lp-1:0] one_lp      = ras_idx_width_lp'(1);

  bp_fe_ras_state_e            state_r;
  logic                        init_done_r;
  logic [ras_idx_width_lp-1:0] clr_idx_r;
  logic [ras_idx_width_lp-1:0] next_r;
  logic [ras_idx_width_lp-1:0] tos_r;
  logic [ras_els_p-1:0]        valid_r;
`ifdef BP_FE_RAS_UNDERFLOW_GUARD_EN
  logic [ras_els_p-1:0]        link_v_r;
  logic                        tos_v_r;
`endif

  logic                        run;
  logic                        do_restore;
  logic                        do_call;
  logic                        do_return;
  logic [mem_width_lp-1:0]     rd_data;
  logic [vaddr_width_p-1:0]    rd_tgt;
  logic [ras_idx_width_lp-1:0] rd_link;
  bp_fe_ras_entry_s            wr_entry;

  // Restore outranks everything and drops a concurrent call/return;
  // nothing is accepted until the clear sweep has finished.
  assign run        = (state_r == e_run);
  assign do_restore = run & ras.restore_i;
  assign do_call    = run & ~ras.restore_i & ras.call_i;
  assign do_return  = run & ~ras.restore_i & ras.return_i;

  bp_fe_ras_linked_mem_1r1w #(
    .width_p (mem_width_lp),
    .els_p   (ras_els_p)
  ) tgt_link_mem (
    .clk_i    (clk_i),
    .w_v_i    (do_call),
    .w_addr_i (next_r),
    .w_data_i ({wr_entry.tgt, wr_entry.link}),
    .r_addr_i (tos_r),
    .r_data_o (rd_data)
  );

  assign rd_tgt  = rd_data[mem_width_lp-1 -: vaddr_width_p];
  assign rd_link = rd_data[ras_idx_width_lp-1:0];

  // Entry written by a push. A plain call links to the current top; a
  // call+return swap replaces the top, so it inherits the popped link.
  always_comb begin
    // NOTE: default every field first so no path leaves one unassigned
    // (an unassigned path would infer a latch).
    wr_entry       = '0;
    wr_entry.tgt   = ras.addr_i;
    wr_entry.valid = 1'b1;
    if (do_return) begin
      wr_entry.link = rd_link;
`ifdef BP_FE_RAS_UNDERFLOW_GUARD_EN
      wr_entry.link_v = link_v_r[tos_r];
`endif
    end else begin
      wr_entry.link = tos_r;
`ifdef BP_FE_RAS_UNDERFLOW_GUARD_EN
      wr_entry.link_v = tos_v_r;
`endif
    end
  end

  // Controller: clear sweep after reset, then push/pop/restore pointer update.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_clear;
      init_done_r <= 1'b0;
      clr_idx_r   <= '0;
      next_r      <= '0;
      tos_r       <= '0;
      valid_r     <= '0;
`ifdef BP_FE_RAS_UNDERFLOW_GUARD_EN
      link_v_r    <= '0;
      tos_v_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        e_clear: begin
          valid_r[clr_idx_r]  <= 1'b0;
`ifdef BP_FE_RAS_UNDERFLOW_GUARD_EN
          link_v_r[clr_idx_r] <= 1'b0;
`endif
          clr_idx_r <= clr_idx_r + one_lp;
          if (clr_idx_r == last_idx_lp) begin
            state_r     <= e_run;
            init_done_r <= 1'b1;
          end
        end
        e_run: begin
          if (do_restore) begin
            next_r  <= ras.w_next_i;
            tos_r   <= ras.w_tos_i;
`ifdef BP_FE_RAS_UNDERFLOW_GUARD_EN
            tos_v_r <= valid_r[ras.w_tos_i];
`endif
          end else if (do_call) begin
            valid_r[next_r]  <= wr_entry.valid;
`ifdef BP_FE_RAS_UNDERFLOW_GUARD_EN
            link_v_r[next_r] <= wr_entry.link_v;
            tos_v_r          <= 1'b1;
`endif
            tos_r  <= next_r;
            next_r <= next_r + one_lp;
          end else if (do_return) begin
            tos_r   <= rd_link;
`ifdef BP_FE_RAS_UNDERFLOW_GUARD_EN
            tos_v_r <= link_v_r[tos_r];
`endif
          end
        end
        default: state_r <= e_clear;
      endcase
    end
  end

  assign ras.init_done_o = init_done_r;
  assign ras.next_o      = next_r;
  assign ras.tos_o       = tos_r;
  // Never-written entries are masked so the target output carries no X.
  assign ras.tgt_o       = valid_r[tos_r] ? rd_tgt : '0;
`ifdef BP_FE_RAS_UNDERFLOW_GUARD_EN
  assign ras.v_o         = tos_v_r & valid_r[tos_r];
`else
  assign ras.v_o         = valid_r[tos_r];
`endif

endmodule

// File: tb/tb_bp_fe_ras_linked.sv
// tb_bp_fe_ras_linked: directed scoreboard bench for the linked RAS.
// Expected outputs are queued alongside each stimulus step and compared
// on the falling edge after the step's active edge.
module tb_bp_fe_ras_linked;

  localparam int vw = 39;
  localparam int els = 8;

`ifdef BP_FE_RAS_UNDERFLOW_GUARD_EN
  localparam logic underflow_v = 1'b0;
`else
  localparam logic underflow_v = 1'b1;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bp_fe_ras_linked_if #(.vaddr_width_p(vw), .ras_els_p(els)) ras_if ();

  bp_fe_ras_linked #(.vaddr_width_p(vw), .ras_els_p(els)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .ras     (ras_if)
  );

  typedef struct {
    string           tag;
    logic            init_done;
    logic            v;
    logic [vw-1:0]   tgt;
    logic [2:0]      nxt;
    logic [2:0]      tos;
  } exp_s;

  exp_s sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic init_done, input logic v,
                            input logic [vw-1:0] tgt, input logic [2:0] nxt, input logic [2:0] tos);
    exp_s e;
    e.tag = tag; e.init_done = init_done; e.v = v; e.tgt = tgt; e.nxt = nxt; e.tos = tos;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_s e;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({e.tag, "/init_done"}, 64'(ras_if.init_done_o), 64'(e.init_done));
      check({e.tag, "/v"},         64'(ras_if.v_o),         64'(e.v));
      check({e.tag, "/tgt"},       64'(ras_if.tgt_o),       64'(e.tgt));
      check({e.tag, "/next"},      64'(ras_if.next_o),      64'(e.nxt));
      check({e.tag, "/tos"},       64'(ras_if.tos_o),       64'(e.tos));
    end
  endtask

  task automatic drive(input logic c, input logic r, input logic rs,
                       input logic [vw-1:0] addr, input logic [2:0] wn, input logic [2:0] wt);
    ras_if.call_i    = c;
    ras_if.return_i  = r;
    ras_if.restore_i = rs;
    ras_if.addr_i    = addr;
    ras_if.w_next_i  = wn;
    ras_if.w_tos_i   = wt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, 3'd0, 3'd0);
  endtask

  // One active edge, then inputs drop to idle and outputs are compared.
  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    drain();
  endtask

  task automatic step(input string tag, input logic c, input logic r, input logic rs,
                      input logic [vw-1:0] addr, input logic [2:0] wn, input logic [2:0] wt,
                      input logic ev, input logic [vw-1:0] etgt, input logic [2:0] en, input logic [2:0] et);
    drive(c, r, rs, addr, wn, wt);
    expect_out(tag, 1'b1, ev, etgt, en, et);
    cycle();
  endtask

  // Reset asserted mid-cycle must clear outputs at once; during the sweep
  // every request is asserted and must be ignored.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_out({tag, "_async"}, 1'b0, 1'b0, '0, 3'd0, 3'd0);
    drain();
    @(negedge clk);
    reset = 1'b0;
    expect_out({tag, "_release"}, 1'b0, 1'b0, '0, 3'd0, 3'd0);
    drain();
    for (int k = 1; k <= els; k++) begin
      drive(1'b1, 1'b1, 1'b1, 39'h7777, 3'd5, 3'd3);
      expect_out($sformatf("%s_sweep%0d", tag, k), (k == els), 1'b0, '0, 3'd0, 3'd0);
      cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();

    // Reset and init sweep.
    do_reset("rst0");

    // Push/pop.
    step("pp_call1",  1, 0, 0, 39'h1000, 0, 0, 1'b1, 39'h1000, 3'd1, 3'd0);
    step("pp_call2",  1, 0, 0, 39'h2000, 0, 0, 1'b1, 39'h2000, 3'd2, 3'd1);
    step("pp_ret1",   0, 1, 0, 39'h0,    0, 0, 1'b1, 39'h1000, 3'd2, 3'd0);
    step("pp_ret2",   0, 1, 0, 39'h0,    0, 0, underflow_v, 39'h1000, 3'd2, 3'd0);

    // Restore after mispredicted returns plus an overwriting push.
    do_reset("rst1");
    step("rs_pushA",  1, 0, 0, 39'hA00, 0, 0, 1'b1, 39'hA00, 3'd1, 3'd0);
    step("rs_pushB",  1, 0, 0, 39'hB00, 0, 0, 1'b1, 39'hB00, 3'd2, 3'd1);
    step("rs_pushC",  1, 0, 0, 39'hC00, 0, 0, 1'b1, 39'hC00, 3'd3, 3'd2);
    step("rs_ret1",   0, 1, 0, 39'h0,   0, 0, 1'b1, 39'hB00, 3'd3, 3'd1);
    step("rs_ret2",   0, 1, 0, 39'h0,   0, 0, 1'b1, 39'hA00, 3'd3, 3'd0);
    step("rs_pushD",  1, 0, 0, 39'hD00, 0, 0, 1'b1, 39'hD00, 3'd4, 3'd3);
    step("rs_restore",0, 0, 1, 39'h0,   3, 2, 1'b1, 39'hC00, 3'd3, 3'd2);
    step("rs_ret3",   0, 1, 0, 39'h0,   0, 0, 1'b1, 39'hB00, 3'd3, 3'd1);

    // Priority: restore with call and return drops both; no entry written.
    step("pri_all",   1, 1, 1, 39'hEEE, 6, 0, 1'b1, 39'hA00, 3'd6, 3'd0);
    step("pri_e3",    0, 0, 1, 39'h0,   3, 3, 1'b1, 39'hD00, 3'd3, 3'd3);
    step("pri_e6",    0, 0, 1, 39'h0,   6, 6, 1'b0, 39'h0,   3'd6, 3'd6);

    // Coroutine swap.
    do_reset("rst2");
    step("sw_push10", 1, 0, 0, 39'h10, 0, 0, 1'b1, 39'h10, 3'd1, 3'd0);
    step("sw_push20", 1, 0, 0, 39'h20, 0, 0, 1'b1, 39'h20, 3'd2, 3'd1);
    step("sw_swap",   1, 1, 0, 39'h30, 0, 0, 1'b1, 39'h30, 3'd3, 3'd2);
    step("sw_ret",    0, 1, 0, 39'h0,  0, 0, 1'b1, 39'h10, 3'd3, 3'd0);

    // Wrap: nine pushes onto an eight-entry stack.
    do_reset("rst3");
    for (int i = 0; i < 9; i++) begin
      step($sformatf("wrap%0d", i), 1, 0, 0, 39'(32'h100 + i), 0, 0,
           1'b1, 39'(32'h100 + i), 3'((i + 1) % els), 3'(i % els));
    end

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
